// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM stage; executes loads/stores byte-serially on a byte-wide memory port.
// Latency: non-memory ops pass through combinationally; a memory op takes 1 IDLE cycle + N acked bytes + 1 DONE cycle.
// Backpressure: stall_req holds upstream while an access is in flight; rdy_in low freezes all state; mc_ack paces bytes.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (global freeze when low)
//   forward/rd_addr/rd_val/ins_type/ins_details/mem_addr/mem_val : latched EX results
//   mc_req/mc_we/mc_addr/mc_wdata -> memory controller; mc_ack/mc_rdata <- memory controller
//   stall_req -> upstream; wb_forward/wb_rd_addr/wb_rd_val -> MEM/WB register and forwarding
//   misalign_err : one-cycle flag for misaligned halfword/word accesses
// Optional feature macro: MEM_ALIGN_CHECK_EN (alignment check; when undefined misalign_err is constant 0).

module mem_stage #(
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        forward,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_val,
  input  logic [6:0]  ins_type,
  input  logic [2:0]  ins_details,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_val,
  output logic        mc_req,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [7:0]  mc_wdata,
  input  logic        mc_ack,
  input  logic [7:0]  mc_rdata,
  output logic        stall_req,
  output logic        wb_forward,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_val,
  output logic        misalign_err
);

  // S_ERR is the single DONE-like cycle of a rejected misaligned access; it is
  // only reachable when the alignment check is compiled in.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] data_buf, data_buf_nxt;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [1:0]  last_idx;
  logic [31:0] load_ext;

  assign is_load  = (ins_type == LOAD_OP);
  assign is_store = (ins_type == STORE_OP);
  assign is_mem   = is_load | is_store;

  // Index of the final byte: funct3[1:0] 00 -> 1 byte, 01 -> 2 bytes,
  // everything else (word and undefined encodings) -> 4 bytes.
  always_comb begin
    last_idx = 2'd3;
    case (ins_details[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (ins_details[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_addr[0];
      default: misaligned = (mem_addr[1:0] != 2'b00);
    endcase
  end
`endif

  // Result extension of the assembled little-endian load data.
  always_comb begin
    load_ext = data_buf;
    case (ins_details)
      3'b000:  load_ext = {{24{data_buf[7]}}, data_buf[7:0]};
      3'b001:  load_ext = {{16{data_buf[15]}}, data_buf[15:0]};
      3'b100:  load_ext = {24'd0, data_buf[7:0]};
      3'b101:  load_ext = {16'd0, data_buf[15:0]};
      default: load_ext = data_buf;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      data_buf <= 32'd0;
    end else if (rdy_in) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data_buf <= data_buf_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    data_buf_nxt = data_buf;
    case (state)
      S_IDLE: begin
        if (is_mem) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt    = S_ACCESS;
            cnt_nxt      = 2'd0;
            data_buf_nxt = 32'd0;
          end
`else
          state_nxt    = S_ACCESS;
          cnt_nxt      = 2'd0;
          data_buf_nxt = 32'd0;
`endif
        end
      end
      S_ACCESS: begin
        if (mc_ack) begin
          if (is_load) begin
            data_buf_nxt[{cnt, 3'b000} +: 8] = mc_rdata;
          end
          if (cnt == last_idx) begin
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. They are forced to zero while rst_in is low so the block presents
  // a quiet interface for the whole reset window, not just after the first edge.
  always_comb begin
    mc_req       = 1'b0;
    mc_we        = 1'b0;
    mc_addr      = 32'd0;
    mc_wdata     = 8'd0;
    stall_req    = 1'b0;
    wb_forward   = 1'b0;
    wb_rd_addr   = 5'd0;
    wb_rd_val    = 32'd0;
    misalign_err = 1'b0;
    if (rst_in) begin
      wb_rd_addr = rd_addr;
      case (state)
        S_IDLE: begin
          if (is_mem) begin
            stall_req = 1'b1;
          end else begin
            wb_forward = forward;
            wb_rd_val  = rd_val;
          end
        end
        S_ACCESS: begin
          mc_req    = 1'b1;
          mc_we     = is_store;
          mc_addr   = mem_addr + {30'd0, cnt};
          mc_wdata  = mem_val[{cnt, 3'b000} +: 8];
          stall_req = 1'b1;
        end
        S_DONE: begin
          if (is_load) begin
            wb_forward = forward;
            wb_rd_val  = load_ext;
          end
        end
        default: begin
`ifdef MEM_ALIGN_CHECK_EN
          misalign_err = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;
  localparam logic [6:0] ALU_OP   = 7'b0010011;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        forward;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic [6:0]  ins_type;
  logic [2:0]  ins_details;
  logic [31:0] mem_addr;
  logic [31:0] mem_val;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic        mc_ack;
  logic [7:0]  mc_rdata;
  logic        stall_req;
  logic        wb_forward;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_val;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .forward(forward), .rd_addr(rd_addr), .rd_val(rd_val),
    .ins_type(ins_type), .ins_details(ins_details),
    .mem_addr(mem_addr), .mem_val(mem_val),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ack(mc_ack), .mc_rdata(mc_rdata),
    .stall_req(stall_req), .wb_forward(wb_forward),
    .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val),
    .misalign_err(misalign_err)
  );

  // One memory transaction: inputs, memory contents/ack delays, expected result.
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wval;
    logic [31:0] rbytes;  // byte k of memory at addr+k is rbytes[8k+:8]
    logic [7:0]  dly;     // wait cycles before acking byte k: dly[2k+:2]
    int          n;       // expected number of acked bytes
    logic        fwd_exp;
    logic [31:0] val_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wval, input logic fwd, input logic [4:0] rd,
                         input logic [31:0] val);
    ins_type    = op;
    ins_details = f3;
    mem_addr    = addr;
    mem_val     = wval;
    forward     = fwd;
    rd_addr     = rd;
    rd_val      = val;
  endtask

  task automatic set_nop();
    set_ins(ALU_OP, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_mem(input vec_t v, input int idx);
    int    k;
    int    w;
    bit    done;
    string tag;
    tag  = $sformatf("v%0d", idx);
    set_ins(v.op, v.f3, v.addr, v.wval, 1'b1, 5'd9, 32'hDEAD0000);
    @(negedge clk_in);
    chk({tag, "_idle_stall"}, stall_req, 1);
    chk({tag, "_idle_req"}, mc_req, 0);
    chk({tag, "_idle_fwd"}, wb_forward, 0);
    k    = 0;
    w    = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      tick();
      mc_ack = 1'b0;
      @(negedge clk_in);
      if (mc_req) begin
        chk({tag, "_acc_stall"}, stall_req, 1);
        chk({tag, "_acc_fwd"}, wb_forward, 0);
        if (k >= 4) begin
          chk({tag, "_extra_req"}, k, 3);
          done = 1;
        end else begin
          chk({tag, "_addr"}, mc_addr, v.addr + 32'(k));
          chk({tag, "_we"}, mc_we, (v.op == STORE_OP));
          if (w == int'(v.dly[2*k +: 2])) begin
            if (v.op == STORE_OP) chk({tag, "_wdata"}, mc_wdata, v.wval[8*k +: 8]);
            mc_ack   = 1'b1;
            mc_rdata = v.rbytes[8*k +: 8];
            k++;
            w = 0;
          end else begin
            w++;
          end
        end
      end else begin
        done = 1;
        chk({tag, "_nbytes"}, k, v.n);
        chk({tag, "_done_stall"}, stall_req, 0);
        chk({tag, "_done_fwd"}, wb_forward, v.fwd_exp);
        chk({tag, "_done_val"}, wb_rd_val, v.val_exp);
        if (v.op == LOAD_OP) chk({tag, "_done_rd"}, wb_rd_addr, 5'd9);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no DONE cycle, expected one within 64 cycles", tag);
    end
    tick();
    mc_ack = 1'b0;
    set_nop();
  endtask

  initial begin
    //            op        f3      addr          wval          rbytes        dly    n  fwd  val
    vecs.push_back('{LOAD_OP,  3'b010, 32'h00000100, 32'h0,        32'h12345678, 8'hD8, 4, 1'b1, 32'h12345678});
    vecs.push_back('{LOAD_OP,  3'b000, 32'h00000020, 32'h0,        32'h00000080, 8'h00, 1, 1'b1, 32'hFFFFFF80});
    vecs.push_back('{LOAD_OP,  3'b100, 32'h00000020, 32'h0,        32'h00000080, 8'h00, 1, 1'b1, 32'h00000080});
    vecs.push_back('{LOAD_OP,  3'b001, 32'h00000030, 32'h0,        32'h00008000, 8'h04, 2, 1'b1, 32'hFFFF8000});
    vecs.push_back('{LOAD_OP,  3'b101, 32'h00000030, 32'h0,        32'h00008000, 8'h00, 2, 1'b1, 32'h00008000});
    vecs.push_back('{STORE_OP, 3'b001, 32'h00000040, 32'hAABBCCDD, 32'h0,        8'h01, 2, 1'b0, 32'h00000000});
    vecs.push_back('{STORE_OP, 3'b010, 32'h00000050, 32'h11223344, 32'h0,        8'h00, 4, 1'b0, 32'h00000000});
    vecs.push_back('{LOAD_OP,  3'b011, 32'h00000060, 32'h0,        32'h04030201, 8'h00, 4, 1'b1, 32'h04030201});
    vecs.push_back('{LOAD_OP,  3'b001, 32'h00000070, 32'h0,        32'h00007F01, 8'h00, 2, 1'b1, 32'h00007F01});
    vecs.push_back('{LOAD_OP,  3'b000, 32'h00000074, 32'h0,        32'h0000007F, 8'h02, 1, 1'b1, 32'h0000007F});
    vecs.push_back('{LOAD_OP,  3'b110, 32'h00000080, 32'h0,        32'h89ABCDEF, 8'h00, 4, 1'b1, 32'h89ABCDEF});
`ifndef MEM_ALIGN_CHECK_EN
    // Misaligned word crossing the top of the address space: byte addresses wrap.
    vecs.push_back('{LOAD_OP,  3'b010, 32'hFFFFFFFE, 32'h0,        32'hA1B2C3D4, 8'h00, 4, 1'b1, 32'hA1B2C3D4});
`endif

    // Reset held for two cycles with a load presented
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    mc_ack   = 1'b0;
    mc_rdata = 8'h00;
    set_ins(LOAD_OP, 3'b000, 32'h00000010, 32'h0, 1'b1, 5'd7, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk_in);
      chk("rst_stall", stall_req, 0);
      chk("rst_req", mc_req, 0);
      chk("rst_we", mc_we, 0);
      chk("rst_addr", mc_addr, 0);
      chk("rst_wdata", mc_wdata, 0);
      chk("rst_fwd", wb_forward, 0);
      chk("rst_rd", wb_rd_addr, 0);
      chk("rst_val", wb_rd_val, 0);
      chk("rst_misalign", misalign_err, 0);
    end
    tick();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("post_rst_idle_stall", stall_req, 1);
    chk("post_rst_idle_req", mc_req, 0);
    tick();
    @(negedge clk_in);
    chk("post_rst_access_req", mc_req, 1);
    chk("post_rst_access_addr", mc_addr, 32'h10);
    mc_ack   = 1'b1;
    mc_rdata = 8'h85;
    tick();
    mc_ack = 1'b0;
    @(negedge clk_in);
    chk("post_rst_done_stall", stall_req, 0);
    chk("post_rst_done_val", wb_rd_val, 32'hFFFFFF85);
    tick();

    // ALU pass-through, with a stray ack that must be ignored
    set_ins(ALU_OP, 3'b000, 32'h0, 32'h0, 1'b1, 5'd5, 32'h00001234);
    mc_ack = 1'b1;
    @(negedge clk_in);
    chk("alu_fwd", wb_forward, 1);
    chk("alu_rd", wb_rd_addr, 5);
    chk("alu_val", wb_rd_val, 32'h1234);
    chk("alu_stall", stall_req, 0);
    chk("alu_req", mc_req, 0);
    tick();
    set_ins(7'b0110011, 3'b000, 32'h0, 32'h0, 1'b0, 5'd31, 32'hDEADBEEF);
    @(negedge clk_in);
    chk("alu2_fwd", wb_forward, 0);
    chk("alu2_rd", wb_rd_addr, 31);
    chk("alu2_val", wb_rd_val, 32'hDEADBEEF);
    chk("alu2_stall", stall_req, 0);
    mc_ack = 1'b0;
    tick();
    set_nop();

    foreach (vecs[i]) run_mem(vecs[i], i);

    // rdy_in low freezes the access even with mc_ack asserted
    set_ins(LOAD_OP, 3'b000, 32'h00000024, 32'h0, 1'b1, 5'd4, 32'h0);
    @(negedge clk_in);
    chk("frz_idle_stall", stall_req, 1);
    tick();
    @(negedge clk_in);
    chk("frz_access_req", mc_req, 1);
    rdy_in   = 1'b0;
    mc_ack   = 1'b1;
    mc_rdata = 8'h11;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk_in);
      chk("frz_hold_req", mc_req, 1);
      chk("frz_hold_addr", mc_addr, 32'h24);
      chk("frz_hold_stall", stall_req, 1);
    end
    rdy_in   = 1'b1;
    mc_rdata = 8'h22;
    tick();
    mc_ack = 1'b0;
    @(negedge clk_in);
    chk("frz_done_stall", stall_req, 0);
    chk("frz_done_val", wb_rd_val, 32'h22);
    tick();
    set_nop();

    // Reset in the middle of an access discards progress
    set_ins(LOAD_OP, 3'b010, 32'h00000200, 32'h0, 1'b1, 5'd3, 32'h0);
    @(negedge clk_in);
    tick();
    @(negedge clk_in);
    chk("mrst_addr0", mc_addr, 32'h200);
    mc_ack   = 1'b1;
    mc_rdata = 8'hAA;
    tick();
    mc_ack = 1'b0;
    @(negedge clk_in);
    chk("mrst_addr1", mc_addr, 32'h201);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("mrst_req_dropped", mc_req, 0);
    chk("mrst_idle_stall", stall_req, 1);
    tick();
    @(negedge clk_in);
    chk("mrst_restart_addr", mc_addr, 32'h200);
    chk("mrst_restart_req", mc_req, 1);
    rst_in = 1'b0;
    set_nop();
    tick();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("mrst_clean_req", mc_req, 0);
    chk("mrst_clean_stall", stall_req, 0);
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word: one error cycle, no memory request
    set_ins(LOAD_OP, 3'b010, 32'h00000102, 32'h0, 1'b1, 5'd6, 32'h0);
    @(negedge clk_in);
    chk("mis_idle_err", misalign_err, 0);
    chk("mis_idle_req", mc_req, 0);
    tick();
    @(negedge clk_in);
    chk("mis_err", misalign_err, 1);
    chk("mis_stall", stall_req, 0);
    chk("mis_req", mc_req, 0);
    chk("mis_fwd", wb_forward, 0);
    tick();
    set_nop();
    @(negedge clk_in);
    chk("mis_err_cleared", misalign_err, 0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
